// File: rtl/uart_tx_mmio_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
// Build option: UART_TX_PARITY_EN adds an even-parity bit to each frame.
package uart_tx_mmio_pkg;

    localparam int REG_W = 32;

    localparam logic [1:0] UART_TXDATA  = 2'd0;
    localparam logic [1:0] UART_STATUS  = 2'd1;
    localparam logic [1:0] UART_DIVISOR = 2'd2;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_PAR   = 4;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_PARITY = 3'd4
    } tx_state_e;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;
`endif

    function automatic logic [15:0] div_eff(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX byte FIFO with MSB-wrap pointers.
// A push into a full FIFO is accepted only when a pop occurs in the same cycle.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp;
    logic [AW:0]  rp;
    logic         push_ok;
    logic         pop_ok;

    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) &&
                     (wp[AW-1:0] == rp[AW-1:0]);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign dout    = mem[rp[AW-1:0]];

    // Pointer update; reset flushes the queue
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push_ok) wp <= wp + 1'b1;
            if (pop_ok)  rp <= rp + 1'b1;
        end
    end

    // Storage write; contents need no reset
    always_ff @(posedge clk) begin
        if (push_ok) mem[wp[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and baud divisor.
// Build option: UART_TX_PARITY_EN inserts an even-parity bit (8E1).
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter int          FIFO_DEPTH       = 8,
    parameter logic [15:0] DIV_RESET        = 16'd434,
    parameter int          BASE_OFFSET_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             we,
    input  logic [31:0]      addr,
    input  logic [3:0]       sel,
    input  logic [REG_W-1:0] data_i,
    output logic [REG_W-1:0] data_o,
    output logic             tx_o,
    output logic             irq_o
);

    logic [BASE_OFFSET_BITS-1:0] loc_addr;
    logic [1:0]  idx;
    logic        wr;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic [7:0]  dout;
    logic        ovf;
    logic [15:0] divisor;
    logic        busy;
    logic        par_bit;

    tx_state_e   state;
    tx_state_e   state_n;
    logic [7:0]  shift;
    logic [2:0]  bit_cnt;
    logic [15:0] tmr;
    logic [15:0] div_lat;
    logic        tick;

    logic unused_ok;
    assign unused_ok = ^{addr[31:BASE_OFFSET_BITS],
                         loc_addr[1:0], data_i[31:16]};

    assign loc_addr = addr[BASE_OFFSET_BITS-1:0];
    assign idx      = loc_addr[3:2];
    assign wr       = ce & we & (|sel);
    assign push     = wr & (idx == UART_TXDATA);
    assign pop      = (state == S_IDLE) & ~empty;
    assign busy     = (state != S_IDLE);
    assign irq_o    = empty & ~busy;
    assign tick     = (tmr == div_lat - 16'd1);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (data_i[7:0]),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

    // Control registers: divisor and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            divisor <= DIV_RESET;
            ovf     <= 1'b0;
        end else begin
            if (wr && idx == UART_DIVISOR)
                divisor <= data_i[15:0];
            if (wr && idx == UART_STATUS)
                ovf <= 1'b0;
            else if (push && full && !pop)
                ovf <= 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // FSM next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (!empty) state_n = S_START;
            S_START: if (tick) state_n = S_DATA;
`ifdef UART_TX_PARITY_EN
            S_DATA:  if (tick && bit_cnt == 3'd7)
                         state_n = S_PARITY;
            S_PARITY: if (tick) state_n = S_STOP;
`else
            S_DATA:  if (tick && bit_cnt == 3'd7)
                         state_n = S_STOP;
`endif
            S_STOP:  if (tick) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Shifter, bit timer and bit counter; divisor latched per frame
    always_ff @(posedge clk) begin
        if (rst) begin
            shift   <= 8'd0;
            bit_cnt <= 3'd0;
            tmr     <= 16'd0;
            div_lat <= 16'd1;
            par_bit <= 1'b0;
        end else if (state == S_IDLE) begin
            if (pop) begin
                shift   <= dout;
                par_bit <= ^dout;
                div_lat <= div_eff(divisor);
                tmr     <= 16'd0;
                bit_cnt <= 3'd0;
            end
        end else begin
            tmr <= tick ? 16'd0 : tmr + 16'd1;
            if (state == S_DATA && tick) begin
                shift   <= {1'b0, shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // FSM output: serial line level per state
    always_comb begin
        tx_o = 1'b1;
        unique case (state)
            S_IDLE:   tx_o = 1'b1;
            S_START:  tx_o = 1'b0;
            S_DATA:   tx_o = shift[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_o = par_bit;
`endif
            S_STOP:   tx_o = 1'b1;
            default:  tx_o = 1'b1;
        endcase
    end

    // Register read mux; no side effects
    always_comb begin
        data_o = '0;
        if (ce) begin
            case (idx)
                UART_STATUS: begin
                    data_o[ST_FULL]  = full;
                    data_o[ST_EMPTY] = empty;
                    data_o[ST_BUSY]  = busy;
                    data_o[ST_OVF]   = ovf;
`ifdef UART_TX_PARITY_EN
                    data_o[ST_PAR]   = 1'b1;
`endif
                end
                UART_DIVISOR: data_o[15:0] = divisor;
                default:      data_o = '0;
            endcase
        end
    end

endmodule
